// File: rtl/bk_pipe_addacc.sv
// Two-stage pipelined Brent-Kung adder/accumulator with valid/ready handshakes.
// Stage 1 forms the operands from the op mode and runs the prefix up-sweep.
// Stage 2 runs the down-sweep, forms sum/cout/ovf and updates the accumulator.
// ACC/LOAD beats hold off new input while in stage 1, so the next ACC sees the updated acc.

module bk_pipe_addacc #(
  parameter int WIDTH  = 32,
  parameter bit SAT_EN = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [WIDTH-1:0] acc
);

  localparam int LOG = $clog2(WIDTH);

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  op_e op_in;
  assign op_in = op_e'(op);

  // Operand formation and up-sweep signals
  logic [WIDTH-1:0] x, y, p_in, gu_in, pu_in;
  logic             c0;
  logic [LOG-1:0]   uhi, ulo;

  // Stage 1 register
  logic             s1_valid;
  op_e              s1_op;
  logic             s1_c0;
  logic             s1_xmsb;
  logic [WIDTH-1:0] s1_p, s1_gu, s1_pu;

  // Down-sweep and result signals
  logic [WIDTH-1:0] gd, carry, raw_sum, fin_sum;
  logic             raw_cout, raw_ovf;
  logic [LOG-1:0]   dhi, dlo;

  // Handshake
  logic s1_serial, s2_load, in_fire;

  // Select X, Y and carry-in for the requested operation
  always_comb begin
    // NOTE: defaults before the case keep every path assigned, so no latch is inferred.
    x  = a;
    y  = b;
    c0 = cin;
    case (op_in)
      OP_SUB:  begin y = ~b; c0 = 1'b1; end
      OP_ACC:  begin x = acc; y = a; end
      OP_LOAD: begin y = '0; c0 = 1'b0; end
      default: ;
    endcase
  end

  // Bit propagate/generate (carry-in folded into bit 0) and Brent-Kung up-sweep
  always_comb begin
    p_in     = x ^ y;
    gu_in    = x & y;
    gu_in[0] = gu_in[0] | (p_in[0] & c0);
    pu_in    = p_in;
    uhi      = '0;
    ulo      = '0;
    for (int l = 0; l < LOG; l++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (((i + 1) % (2 << l)) == 0) begin
          uhi        = LOG'(i);
          ulo        = LOG'(i - (1 << l));
          gu_in[uhi] = gu_in[uhi] | (pu_in[uhi] & gu_in[ulo]);
          pu_in[uhi] = pu_in[uhi] & pu_in[ulo];
        end
      end
    end
  end

  // Down-sweep fills in the remaining prefix carries; then sum, flags and saturation
  always_comb begin
    gd  = s1_gu;
    dhi = '0;
    dlo = '0;
    for (int l = LOG - 2; l >= 0; l--) begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((i >= (3 << l) - 1) && (((i + 1 - (1 << l)) % (2 << l)) == 0)) begin
          dhi     = LOG'(i);
          dlo     = LOG'(i - (1 << l));
          gd[dhi] = gd[dhi] | (s1_pu[dhi] & gd[dlo]);
        end
      end
    end
    carry    = {gd[WIDTH-2:0], s1_c0};
    raw_sum  = s1_p ^ carry;
    raw_cout = gd[WIDTH-1];
    raw_ovf  = carry[WIDTH-1] ^ raw_cout;
    fin_sum  = raw_sum;
    if (SAT_EN && (s1_op == OP_ACC) && raw_ovf) begin
      fin_sum = s1_xmsb ? SAT_MIN : SAT_MAX;
    end
  end

  // Pipeline flow control: S2 refills when free, S1 drains into S2, ACC/LOAD serialise
  always_comb begin
    s1_serial = s1_valid && ((s1_op == OP_ACC) || (s1_op == OP_LOAD));
    s2_load   = s1_valid && (!out_valid || out_ready);
    in_ready  = (!s1_valid || s2_load) && !s1_serial;
    in_fire   = in_valid && in_ready;
  end

  // Stage 1 register: captures operands and up-swept prefix groups
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_ADD;
      s1_c0    <= 1'b0;
      s1_xmsb  <= 1'b0;
      s1_p     <= '0;
      s1_gu    <= '0;
      s1_pu    <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_op    <= op_in;
      s1_c0    <= c0;
      s1_xmsb  <= x[WIDTH-1];
      s1_p     <= p_in;
      s1_gu    <= gu_in;
      s1_pu    <= pu_in;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2 register: result held stable until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      sum       <= fin_sum;
      cout      <= raw_cout;
      ovf       <= raw_ovf;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Accumulator: clear wins over the update from an ACC/LOAD moving into stage 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (s2_load && s1_serial) begin
      acc <= fin_sum;
    end
  end

endmodule

// File: tb/tb_bk_pipe_addacc.sv
// Self-checking bench for bk_pipe_addacc (WIDTH=32, SAT_EN=1).
// Directed scenarios plus a randomised stream scored against an arithmetic model.

module tb_bk_pipe_addacc;

  localparam int W = 32;

  logic         clk, rst_n, in_valid, in_ready, cin, acc_clr, out_valid, out_ready, cout, ovf;
  logic [1:0]   op;
  logic [W-1:0] a, b, sum, acc;

  bk_pipe_addacc #(.WIDTH(W), .SAT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .cin(cin), .acc_clr(acc_clr), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .acc(acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  int           tests_run, tests_failed;
  res_t         sb_q[$];
  res_t         exp_r;
  bit           have_exp, sb_en;
  logic [W-1:0] model_acc;

  bit           fired_in, fired_out;
  logic [W-1:0] obs_sum, obs_acc;
  logic         obs_cout, obs_ovf, obs_out_valid, obs_in_ready;

  // Reference: plain wide arithmetic on the operands each op mode selects
  function automatic res_t model(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic ci);
    logic [W-1:0] x, y;
    logic         c;
    logic [W:0]   full;
    res_t         r;
    case (o)
      2'd0:    begin x = av;        y = bv;  c = ci;   end
      2'd1:    begin x = av;        y = ~bv; c = 1'b1; end
      2'd2:    begin x = model_acc; y = av;  c = ci;   end
      default: begin x = av;        y = '0;  c = 1'b0; end
    endcase
    full   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    r.op   = o;
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (x[W-1] == y[W-1]) && (r.sum[W-1] != x[W-1]);
    if (o == 2'd2 && r.ovf) r.sum = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    if (o[1]) model_acc = r.sum;
    return r;
  endfunction

  // One clock: sample at the falling edge (predicts both handshakes), then step past the rising edge
  task automatic tick();
    @(negedge clk);
    fired_in      = in_valid && in_ready;
    fired_out     = out_valid && out_ready;
    obs_sum       = sum;
    obs_cout      = cout;
    obs_ovf       = ovf;
    obs_acc       = acc;
    obs_out_valid = out_valid;
    obs_in_ready  = in_ready;
    have_exp      = 1'b0;
    if (sb_en && fired_out && sb_q.size() > 0) begin
      exp_r    = sb_q.pop_front();
      have_exp = 1'b1;
    end
    if (sb_en && fired_in) sb_q.push_back(model(op, a, b, cin));
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic ci);
    op  = o;
    a   = av;
    b   = bv;
    cin = ci;
  endtask

  // Push one beat into an empty pipe and leave its result waiting in stage 2
  task automatic one_beat(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic ci);
    set_beat(o, av, bv, ci);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if ({out_valid, sum, cout, ovf, acc} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: out_valid=%b sum=%h cout=%b ovf=%b acc=%h, required all zero",
               out_valid, sum, cout, ovf, acc);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_first_add();
    sb_en = 1'b0;
    set_beat(2'd0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tests_run++;
    if (!fired_in || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL first_add_lat1: accepted=%b out_valid=%b, required 1/0", fired_in, out_valid);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL first_add_lat2: out_valid=%b required 1", out_valid);
    end
    tests_run++;
    if ({sum, cout, ovf} !== {32'h0000_0100, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL first_add_value: sum=%h cout=%b ovf=%b, required 00000100/0/0", sum, cout, ovf);
    end
    consume();
  endtask

  task automatic test_arith();
    vec_t vecs[7];
    sb_en   = 1'b0;
    vecs[0] = '{2'd1, 32'd5,         32'd7,         1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[1] = '{2'd1, 32'd7,         32'd5,         1'b0, 32'h0000_0002, 1'b1, 1'b0};
    vecs[2] = '{2'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[3] = '{2'd0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[4] = '{2'd0, 32'd1,         32'd1,         1'b1, 32'h0000_0003, 1'b0, 1'b0};
    vecs[5] = '{2'd1, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[6] = '{2'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      one_beat(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
      tests_run++;
      if (out_valid !== 1'b1 || {sum, cout, ovf} !== {vecs[i].s, vecs[i].co, vecs[i].ov}) begin
        tests_failed++;
        $display("FAIL arith_%0d: out_valid=%b sum=%h cout=%b ovf=%b, required 1 %h %b %b", i,
                 out_valid, sum, cout, ovf, vecs[i].s, vecs[i].co, vecs[i].ov);
      end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    int           sent, got, first_c, last_c, stall;
    bit           stalling, held_v, done;
    logic [W-1:0] held;
    sent = 0; got = 0; first_c = -1; last_c = -1; stall = 0; held_v = 1'b0; done = 1'b0;
    held = '0;
    sb_en = 1'b1;
    for (int c = 0; c < 80; c++) begin
      stalling = 1'b0;
      set_beat(2'd0, $urandom, $urandom, 1'($urandom_range(0, 1)));
      if (got < 8) begin
        out_ready = 1'b1;
        in_valid  = (sent < 8);
      end else if (stall < 4) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        stalling  = 1'b1;
      end else begin
        out_ready = 1'b1;
        in_valid  = 1'b0;
      end
      tick();
      if (fired_in) sent++;
      if (fired_out) begin
        tests_run++;
        if (!have_exp) begin
          tests_failed++;
          $display("FAIL b2b_result: unexpected output sum=%h", obs_sum);
        end else if ({obs_sum, obs_cout, obs_ovf} !== {exp_r.sum, exp_r.cout, exp_r.ovf}) begin
          tests_failed++;
          $display("FAIL b2b_result: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                   obs_sum, obs_cout, obs_ovf, exp_r.sum, exp_r.cout, exp_r.ovf);
        end
        got++;
        if (got == 1) first_c = c;
        if (got == 8) last_c = c;
      end
      if (stalling) begin
        if (obs_out_valid) begin
          if (held_v) begin
            tests_run++;
            if (obs_sum !== held) begin
              tests_failed++;
              $display("FAIL b2b_hold: sum moved to %h while held at %h", obs_sum, held);
            end
          end else begin
            held   = obs_sum;
            held_v = 1'b1;
          end
        end
        stall++;
        if (stall == 4) begin
          tests_run++;
          if (obs_in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_in_ready: got %b with both stages full, required 0", obs_in_ready);
          end
        end
      end else if (stall >= 4 && sb_q.size() == 0 && !obs_out_valid) begin
        done = 1'b1;
        break;
      end
    end
    tests_run++;
    if (last_c - first_c != 7) begin
      tests_failed++;
      $display("FAIL b2b_consecutive: 8 results spanned %0d cycles, required 7", last_c - first_c);
    end
    tests_run++;
    if (!done || got != sent) begin
      tests_failed++;
      $display("FAIL b2b_count: drained=%b results=%0d, required beats=%0d", done, got, sent);
    end
  endtask

  task automatic test_acc_load();
    logic [1:0]   ops[4];
    logic [W-1:0] vals[4];
    logic [W-1:0] accs[4];
    int           acc_cyc[4];
    int           sent, got;
    ops  = '{2'd3, 2'd2, 2'd2, 2'd2};
    vals = '{32'd10, 32'd5, 32'd3, 32'd2};
    accs = '{32'd10, 32'd15, 32'd18, 32'd20};
    acc_cyc = '{0, 0, 0, 0};
    sent = 0; got = 0;
    sb_en = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      in_valid = (sent < 4);
      if (sent < 4) set_beat(ops[sent], vals[sent], $urandom, 1'b0);
      tick();
      if (fired_in) begin
        acc_cyc[sent] = c;
        sent++;
      end
      if (fired_out) begin
        tests_run++;
        if (!have_exp || {obs_sum, obs_cout, obs_ovf} !== {exp_r.sum, exp_r.cout, exp_r.ovf}) begin
          tests_failed++;
          $display("FAIL accload_result: got sum=%h cout=%b ovf=%b, expected sum=%h (have=%b)",
                   obs_sum, obs_cout, obs_ovf, exp_r.sum, have_exp);
        end
        tests_run++;
        if (got < 4 && obs_acc !== accs[got]) begin
          tests_failed++;
          $display("FAIL accload_acc_%0d: got %h required %h", got, obs_acc, accs[got]);
        end
        got++;
        if (got == 4) break;
      end
    end
    in_valid = 1'b0;
    tests_run++;
    if (got != 4 || acc_cyc[3] - acc_cyc[0] != 6) begin
      tests_failed++;
      $display("FAIL accload_rate: results=%0d accept span=%0d cycles, required 4 and 6", got,
               acc_cyc[3] - acc_cyc[0]);
    end
    tests_run++;
    if (acc !== 32'd20) begin
      tests_failed++;
      $display("FAIL accload_final: acc=%h required 00000014", acc);
    end
  endtask

  task automatic test_sat();
    sb_en = 1'b0;
    one_beat(2'd3, 32'h7FFF_FFF0, $urandom, 1'b0);
    consume();
    one_beat(2'd2, 32'h0000_0020, $urandom, 1'b0);
    tests_run++;
    if ({sum, cout, ovf, acc} !== {32'h7FFF_FFFF, 1'b0, 1'b1, 32'h7FFF_FFFF}) begin
      tests_failed++;
      $display("FAIL sat_pos: sum=%h cout=%b ovf=%b acc=%h, required 7fffffff 0 1 7fffffff",
               sum, cout, ovf, acc);
    end
    consume();
    one_beat(2'd3, 32'h8000_0005, $urandom, 1'b0);
    consume();
    one_beat(2'd2, 32'hFFFF_FFF0, $urandom, 1'b0);
    tests_run++;
    if ({sum, cout, ovf, acc} !== {32'h8000_0000, 1'b1, 1'b1, 32'h8000_0000}) begin
      tests_failed++;
      $display("FAIL sat_neg: sum=%h cout=%b ovf=%b acc=%h, required 80000000 1 1 80000000",
               sum, cout, ovf, acc);
    end
    consume();
    // Clear lands on the same edge the ACC moves into stage 2
    set_beat(2'd2, 32'd3, $urandom, 1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    acc_clr  = 1'b1;
    tick();
    acc_clr = 1'b0;
    tests_run++;
    if ({out_valid, sum, acc} !== {1'b1, 32'h8000_0003, 32'h0}) begin
      tests_failed++;
      $display("FAIL sat_clr: out_valid=%b sum=%h acc=%h, required 1 80000003 00000000",
               out_valid, sum, acc);
    end
    consume();
    one_beat(2'd2, 32'd9, $urandom, 1'b0);
    tests_run++;
    if ({sum, acc} !== {32'd9, 32'd9}) begin
      tests_failed++;
      $display("FAIL sat_after_clr: sum=%h acc=%h, required 00000009 00000009", sum, acc);
    end
    consume();
    model_acc = 32'd9;
  endtask

  task automatic test_random();
    bit drained;
    drained = 1'b0;
    sb_en   = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if (c < 400) begin
        in_valid  = ($urandom_range(0, 9) < 7);
        out_ready = ($urandom_range(0, 9) < 7);
        set_beat(2'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom_range(0, 1)));
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      tick();
      if (fired_out) begin
        tests_run++;
        if (!have_exp) begin
          tests_failed++;
          $display("FAIL rand_result: unexpected output sum=%h", obs_sum);
        end else begin
          if ({obs_sum, obs_cout, obs_ovf} !== {exp_r.sum, exp_r.cout, exp_r.ovf}) begin
            tests_failed++;
            $display("FAIL rand_result: op=%0d got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                     exp_r.op, obs_sum, obs_cout, obs_ovf, exp_r.sum, exp_r.cout, exp_r.ovf);
          end
          if (exp_r.op[1]) begin
            tests_run++;
            if (obs_acc !== exp_r.sum) begin
              tests_failed++;
              $display("FAIL rand_acc: got %h expected %h", obs_acc, exp_r.sum);
            end
          end
        end
      end
      if (c >= 400 && sb_q.size() == 0 && !obs_out_valid) begin
        drained = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!drained || acc !== model_acc) begin
      tests_failed++;
      $display("FAIL rand_final: drained=%b acc=%h expected acc=%h", drained, acc, model_acc);
    end
  endtask

  task automatic test_reset_mid();
    sb_en = 1'b0;
    set_beat(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({out_valid, sum, cout, ovf, acc} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid: out_valid=%b sum=%h cout=%b ovf=%b acc=%h, required all zero",
               out_valid, sum, cout, ovf, acc);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      tests_run++;
      if (obs_out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_stale_%0d: out_valid=%b required 0", i, obs_out_valid);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, ran=%0d failed=%0d", tests_run, tests_failed);
    $fatal(1);
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    sb_en        = 1'b0;
    model_acc    = '0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    acc_clr      = 1'b0;
    set_beat(2'd0, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_first_add();
    test_arith();
    test_back_to_back();
    test_acc_load();
    test_sat();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
